button_gesture_detector: RTL

//  Consumes a debounced, active-high push-button level and classifies it into

---
 rtl/button_gesture_detector_pkg.sv | 26 ++
 rtl/button_gesture_detector_edge_detect.sv | 38 +++
 rtl/button_gesture_detector.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/button_gesture_detector_pkg.sv
// Shared constants for the button gesture detector and related UI blocks.
// State encodings are exported as plain localparams for reuse.
package button_gesture_detector_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_GAP    = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_LONG   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        PRESS1 = ST_PRESS1,
        GAP    = ST_GAP,
        PRESS2 = ST_PRESS2,
        LONG   = ST_LONG
    } gesture_state_e;

    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_gesture_detector_edge_detect.sv
// Edge detector for a debounced level: combinational rise/fall strobes
// against a history flop, plus a registered copy of the level.
module button_gesture_detector_edge_detect (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Sig,
    output logic o_Rise,
    output logic o_Fall,
    output logic o_Level
);

    logic prev_q;
    logic prev_d;
    logic level_q;
    logic level_d;

    // History tracks the input even in reset, so a level held through
    // reset is not mistaken for a fresh edge afterwards.
    always_comb begin
        prev_d  = i_Sig;
        level_d = i_Sig;
    end

    // History and registered level flops.
    always_ff @(posedge i_Clk) begin
        prev_q <= prev_d;
        if (i_Reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign o_Rise  = i_Sig & ~prev_q;
    assign o_Fall  = ~i_Sig & prev_q;
    assign o_Level = level_q;

endmodule

// File: rtl/button_gesture_detector.sv
// Classifies a debounced button level into press, release, single/double
// click and long-press pulses, all registered and one cycle wide.
module button_gesture_detector
    import button_gesture_detector_pkg::*;
#(
    parameter int unsigned LONG_PRESS_CYCLES = 25_000_000,
    parameter int unsigned DOUBLE_GAP_CYCLES = 6_250_000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Debounced,
    output logic o_Press,
    output logic o_Release,
    output logic o_Single_Click,
    output logic o_Double_Click,
    output logic o_Long_Press,
    output logic o_Held
);

    localparam int unsigned CW =
        $clog2(max_u(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES) + 1);

    // Counter is 0 in the cycle an event pulse is visible, so the
    // terminal value sits one below the programmed distance.
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(DOUBLE_GAP_CYCLES - 1);

    logic rise;
    logic fall;
    logic level;

    gesture_state_e state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           press_q, press_d;
    logic           release_q, release_d;
    logic           single_q, single_d;
    logic           double_q, double_d;
    logic           long_q, long_d;

    button_gesture_detector_edge_detect u_edge (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Sig   (i_Debounced),
        .o_Rise  (rise),
        .o_Fall  (fall),
        .o_Level (level)
    );

    // Next-state, counter and event decode for the gesture FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = rise;
        release_d = fall;
        single_d  = 1'b0;
        double_d  = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESS1;
                    cnt_d   = '0;
                end
            end
            PRESS1: begin
                if (fall) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (rise) begin
                    state_d = PRESS2;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    single_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESS2: begin
                if (fall) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    double_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered event outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            single_q  <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            single_q  <= single_d;
            double_q  <= double_d;
            long_q    <= long_d;
        end
    end

    assign o_Press        = press_q;
    assign o_Release      = release_q;
    assign o_Single_Click = single_q;
    assign o_Double_Click = double_q;
    assign o_Long_Press   = long_q;
    assign o_Held         = level;

endmodule
